// File: rtl/ssd_driver_pkg.sv
// Shared FSM encodings, segment patterns and BCD helpers for the 4-digit display driver.
package ssd_driver_pkg;

  localparam int BIN_W        = 13;
  localparam int BCD_W        = 16;
  localparam int SHIFT_CYCLES = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_D0    = 7'b1000000;
  localparam logic [6:0] SEG_D1    = 7'b1111001;
  localparam logic [6:0] SEG_D2    = 7'b0100100;
  localparam logic [6:0] SEG_D3    = 7'b0110000;
  localparam logic [6:0] SEG_D4    = 7'b0011001;
  localparam logic [6:0] SEG_D5    = 7'b0010010;
  localparam logic [6:0] SEG_D6    = 7'b0000010;
  localparam logic [6:0] SEG_D7    = 7'b1111000;
  localparam logic [6:0] SEG_D8    = 7'b0000000;
  localparam logic [6:0] SEG_D9    = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_D0;
      4'd1:    return SEG_D1;
      4'd2:    return SEG_D2;
      4'd3:    return SEG_D3;
      4'd4:    return SEG_D4;
      4'd5:    return SEG_D5;
      4'd6:    return SEG_D6;
      4'd7:    return SEG_D7;
      4'd8:    return SEG_D8;
      4'd9:    return SEG_D9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < BCD_W / 4; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential 13-bit binary to 4-digit BCD converter; result register updates in DONE.
module bin2bcd
  import ssd_driver_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin_i,
  output logic [BCD_W-1:0]    bcd_o,
  output logic                busy_o
);

  conv_state_t             state;
  logic [BIN_W-1:0]        bin_r;
  logic [BIN_W-1:0]        last_r;
  logic [BCD_W-1:0]        acc;
  logic [3:0]              cnt;
  logic                    force_r;
  logic [BCD_W+BIN_W-1:0]  shifted;

  assign shifted = {dabble_adj(acc), bin_r} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      force_r <= 1'b1;
      acc     <= '0;
      bcd_o   <= '0;
      bin_r   <= '0;
      last_r  <= '0;
      cnt     <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (force_r || (bin_i != last_r)) begin
            last_r  <= bin_i;
            bin_r   <= bin_i;
            force_r <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            busy_o  <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // 13 shift cycles, then one hold cycle so DONE commits on capture+15
          if (cnt < 4'(SHIFT_CYCLES)) begin
            {acc, bin_r} <= shifted;
            cnt          <= cnt + 4'd1;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_o  <= acc;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ssd_driver.sv
// 4-digit multiplexed 7-segment driver with on-the-fly binary-to-BCD conversion.
// Define SSD_LZB_EN to blank leading zero digits (digit 0 always shown).
module ssd_driver
  import ssd_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  value_i,
  output logic [3:0]        anode_o,
  output logic [6:0]        seg_o,
  output logic              busy_o
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [BCD_W-1:0] disp;
  logic [3:0]       nib;
  logic             blank;

  bin2bcd u_conv (
    .clk    (clk),
    .rst    (rst),
    .bin_i  (value_i),
    .bcd_o  (disp),
    .busy_o (busy_o)
  );

  assign nib = disp[{idx, 2'b00} +: 4];

`ifdef SSD_LZB_EN
  logic [BCD_W-1:0] upper;
  // Digit is a leading zero when it and everything above it are zero
  assign upper = disp >> {idx, 2'b00};
  assign blank = (idx != 2'd0) && (upper == '0);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      anode_o <= 4'b1110;
      seg_o   <= SEG_D0;
    end else begin
      if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      anode_o <= ~(4'b0001 << idx);
      seg_o   <= blank ? SEG_BLANK : seg_decode(nib);
    end
  end

endmodule

// File: tb/tb_ssd_driver.sv
// Randomized bench for ssd_driver against a timing-level reference model.
module tb_ssd_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] value_i = '0;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  ssd_driver #(.REFRESH_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .value_i (value_i),
    .anode_o (anode_o),
    .seg_o   (seg_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model state: k = edges since the last reset edge
  int k, cap_k, done_k, free_k, last_v, pend_v, disp, prev_disp;
  bit cap_v, pend, force_f;
  logic [3:0] exp_anode;
  logic [6:0] exp_seg;
  logic       exp_busy;
  int p10 [4] = '{1, 10, 100, 1000};
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    if (obs != expv) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (edge %0d, t=%0t)", tag, obs, expv, k, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int val, input int pos);
    bit lz;
    lz = 1'b0;
`ifdef SSD_LZB_EN
    lz = (pos > 0) && (val < p10[pos]);
`endif
    return lz ? 7'b1111111 : pat[(val / p10[pos]) % 10];
  endfunction

  task automatic model_step(input bit r, input int v);
    int pos;
    if (r) begin
      k = 0; force_f = 1; disp = 0; prev_disp = 0; free_k = 1;
      cap_v = 0; pend = 0; last_v = 0;
      exp_anode = 4'b1110; exp_seg = 7'b1000000; exp_busy = 1'b0;
      return;
    end
    k++;
    prev_disp = disp;
    if (pend && k == done_k) begin
      disp = pend_v;
      pend = 0;
    end
    if (k >= free_k && (force_f || v != last_v)) begin
      last_v = v; force_f = 0; pend_v = v; pend = 1;
      cap_k = k; cap_v = 1; done_k = k + 15; free_k = k + 16;
    end
    exp_busy  = cap_v && (k >= cap_k) && (k < cap_k + 15);
    pos       = ((k - 1) / DIV) % 4;
    exp_anode = ~(4'b0001 << pos);
    exp_seg   = model_seg(prev_disp, pos);
  endtask

  task automatic tick(input bit r, input int v);
    rst     = r;
    value_i = 13'(v);
    @(posedge clk);
    model_step(r, v);
    #1;
    chk("anode", int'(anode_o), int'(exp_anode));
    chk("seg",   int'(seg_o),   int'(exp_seg));
    chk("busy",  int'(busy_o),  int'(exp_busy));
  endtask

  task automatic hold(input bit r, input int v, input int n);
    for (int i = 0; i < n; i++) tick(r, v);
  endtask

  initial begin
    int v, n;
    hold(1, 0, 2);
    // zero display, all phases show 0
    hold(0, 0, 40);
    // max value 8191
    hold(0, 8191, 40);
    // value changes mid-conversion: newest captured right after
    hold(0, 1234, 6);
    hold(0, 4321, 40);
    // leading-zero case
    hold(0, 7, 40);
    // reset pulse mid-conversion abandons it, then recaptures
    hold(0, 5000, 8);
    hold(1, 5000, 1);
    hold(0, 5000, 40);
    // boundary: value returning to the previous one after reset
    hold(1, 0, 1);
    hold(0, 0, 20);
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(10, 999);
        default: v = $urandom_range(0, 8191);
      endcase
      n = $urandom_range(1, 25);
      if ($urandom_range(0, 40) == 0) hold(1, v, 1);
      hold(0, v, n);
    end
    hold(0, 9999 % 8192, 40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
